// File: rtl/jk_pkg.sv
// Shared mode encoding and JK pair constants for the multimode register.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_COUNT = 2'b11
  } jk_mode_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop bit with synchronous active-low reset and update enable.
module jk_ff_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= rst_val;
    end else if (en) begin
      case ({j, k})
        JK_HOLD: r_q <= r_q;
        JK_CLR:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TGL:  r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_multimode_reg.sv
// WIDTH-bit register of JK cells: per-bit JK, parallel load, serial shift and
// up/down count, every mode expressed as J/K drive into the cells.
module jk_multimode_reg
  import jk_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
  parameter bit                SHIFT_LEFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] chg,
  output logic             tc
);

  jk_mode_e         w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_chg;

  assign w_mode = jk_mode_e'(mode);

  // T-chain: bit i toggles when all lower bits match the carry/borrow value.
  always_comb begin
    logic run;
    w_t = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_t[i] = run;
      run    = run & (dir ? w_q[i] : ~w_q[i]);
    end
  end

  always_comb begin
    if (SHIFT_LEFT) w_shift = {w_q[WIDTH-2:0], ser_in};
    else            w_shift = {ser_in, w_q[WIDTH-1:1]};
  end

  always_comb begin
    w_j = '0;
    w_k = '0;
    case (w_mode)
      MODE_JK:    begin w_j = j;       w_k = k;        end
      MODE_LOAD:  begin w_j = d;       w_k = ~d;       end
      MODE_SHIFT: begin w_j = w_shift; w_k = ~w_shift; end
      MODE_COUNT: begin w_j = w_t;     w_k = w_t;      end
      default:    begin w_j = '0;      w_k = '0;       end
    endcase
  end

  // Mirror of the cell transfer function, needed for the change flags.
  always_comb begin
    w_next = w_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case ({w_j[i], w_k[i]})
        JK_HOLD: w_next[i] = w_q[i];
        JK_CLR:  w_next[i] = 1'b0;
        JK_SET:  w_next[i] = 1'b1;
        JK_TGL:  w_next[i] = ~w_q[i];
        default: w_next[i] = w_q[i];
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_ff_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .rst_val (RESET_VAL[gi]),
      .j       (w_j[gi]),
      .k       (w_k[gi]),
      .q       (w_q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  r_chg <= '0;
    else if (en) r_chg <= w_next ^ w_q;
    else         r_chg <= '0;
  end

  assign q     = w_q;
  assign q_bar = ~w_q;
  assign chg   = r_chg;
  assign tc    = en & (w_mode == MODE_COUNT) &
                 ((dir & (&w_q)) | (~dir & ~(|w_q)));

endmodule

// File: tb/tb_jk_multimode_reg.sv
// Directed self-checking bench for jk_multimode_reg (WIDTH=8, RESET_VAL=0, SHIFT_LEFT=1).
module tb_jk_multimode_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] d;
  logic       ser_in;
  logic       dir;
  logic [7:0] q;
  logic [7:0] q_bar;
  logic [7:0] chg;
  logic       tc;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] M_JK    = 2'b00;
  localparam logic [1:0] M_LOAD  = 2'b01;
  localparam logic [1:0] M_SHIFT = 2'b10;
  localparam logic [1:0] M_COUNT = 2'b11;

  jk_multimode_reg #(
    .WIDTH      (8),
    .RESET_VAL  (8'h00),
    .SHIFT_LEFT (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .j      (j),
    .k      (k),
    .d      (d),
    .ser_in (ser_in),
    .dir    (dir),
    .q      (q),
    .q_bar  (q_bar),
    .chg    (chg),
    .tc     (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] val);
    mode = M_LOAD;
    d    = val;
    en   = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = M_LOAD; d = 8'hFF;
    tick();
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got=%h exp=%h", q_bar, 8'hFF); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL reset_chg got=%h exp=%h", chg, 8'h00); end
    rst_n = 1'b1;
    tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL release_q got=%h exp=%h", q, 8'hFF); end
    checks++; if (chg !== 8'hFF) begin errors++; $display("FAIL release_chg got=%h exp=%h", chg, 8'hFF); end
  endtask

  task automatic test_jk();
    load(8'hA5);
    mode = M_JK; j = 8'hF0; k = 8'h3C;
    tick();
    checks++; if (q !== 8'hD1) begin errors++; $display("FAIL jk_q got=%h exp=%h", q, 8'hD1); end
    checks++; if (q_bar !== 8'h2E) begin errors++; $display("FAIL jk_qbar got=%h exp=%h", q_bar, 8'h2E); end
    checks++; if (chg !== 8'h74) begin errors++; $display("FAIL jk_chg got=%h exp=%h", chg, 8'h74); end
  endtask

  task automatic test_count_wrap();
    load(8'hFE);
    mode = M_COUNT; dir = 1'b1;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_fe got=%b exp=0", tc); end
    tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL up_q_ff got=%h exp=%h", q, 8'hFF); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL up_tc_ff got=%b exp=1", tc); end
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL up_wrap_q got=%h exp=%h", q, 8'h00); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_wrap_tc got=%b exp=0", tc); end
    checks++; if (chg !== 8'hFF) begin errors++; $display("FAIL up_wrap_chg got=%h exp=%h", chg, 8'hFF); end
    load(8'h01);
    mode = M_COUNT; dir = 1'b0;
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL dn_q_00 got=%h exp=%h", q, 8'h00); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn_tc got=%b exp=1", tc); end
    tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dn_wrap_q got=%h exp=%h", q, 8'hFF); end
  endtask

  task automatic test_shift();
    load(8'h80);
    mode = M_SHIFT; ser_in = 1'b1;
    tick();
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL shift1_q got=%h exp=%h", q, 8'h01); end
    checks++; if (chg !== 8'h81) begin errors++; $display("FAIL shift1_chg got=%h exp=%h", chg, 8'h81); end
    ser_in = 1'b0;
    tick();
    checks++; if (q !== 8'h02) begin errors++; $display("FAIL shift2_q got=%h exp=%h", q, 8'h02); end
    checks++; if (chg !== 8'h03) begin errors++; $display("FAIL shift2_chg got=%h exp=%h", chg, 8'h03); end
  endtask

  task automatic test_enable();
    load(8'hFF);
    mode = M_COUNT; dir = 1'b1; en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (q !== 8'hFF) begin errors++; $display("FAIL en0_q[%0d] got=%h exp=%h", n, q, 8'hFF); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL en0_tc[%0d] got=%b exp=0", n, tc); end
      checks++; if (chg !== 8'h00) begin errors++; $display("FAIL en0_chg[%0d] got=%h exp=%h", n, chg, 8'h00); end
    end
    en = 1'b1;
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL en1_tc got=%b exp=1", tc); end
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL en1_q got=%h exp=%h", q, 8'h00); end
  endtask

  task automatic test_reset_mid_count();
    load(8'h41);
    mode = M_COUNT; dir = 1'b1;
    tick();
    checks++; if (q !== 8'h42) begin errors++; $display("FAIL mid_pre_q got=%h exp=%h", q, 8'h42); end
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 8'h42) begin errors++; $display("FAIL mid_noasync_q got=%h exp=%h", q, 8'h42); end
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_rst_q got=%h exp=%h", q, 8'h00); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL mid_rst_chg got=%h exp=%h", chg, 8'h00); end
    rst_n = 1'b1;
    tick();
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL mid_resume_q got=%h exp=%h", q, 8'h01); end
    checks++; if (chg !== 8'h01) begin errors++; $display("FAIL mid_resume_chg got=%h exp=%h", chg, 8'h01); end
  endtask

  // Mode changes every edge; unused inputs are driven to X and must not leak.
  task automatic test_back_to_back();
    load(8'h3C);
    mode = M_JK; j = 8'h00; k = 8'h00; d = 'x; ser_in = 1'bx; dir = 1'bx;
    tick();
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL b2b_hold_q got=%h exp=%h", q, 8'h3C); end
    mode = M_SHIFT; ser_in = 1'b1; j = 'x; k = 'x;
    tick();
    checks++; if (q !== 8'h79) begin errors++; $display("FAIL b2b_shift_q got=%h exp=%h", q, 8'h79); end
    mode = M_COUNT; dir = 1'b0; ser_in = 1'bx;
    tick();
    checks++; if (q !== 8'h78) begin errors++; $display("FAIL b2b_count_q got=%h exp=%h", q, 8'h78); end
    checks++; if (chg !== 8'h01) begin errors++; $display("FAIL b2b_count_chg got=%h exp=%h", chg, 8'h01); end
    mode = M_LOAD; d = 8'h5A; dir = 1'bx;
    tick();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL b2b_load_q got=%h exp=%h", q, 8'h5A); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL b2b_load_tc got=%b exp=0", tc); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = M_JK;
    j = '0; k = '0; d = '0; ser_in = 1'b0; dir = 1'b1;
    #2;
    test_reset();
    test_jk();
    test_count_wrap();
    test_shift();
    test_enable();
    test_reset_mid_count();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
